// File: rtl/group_accumulator.sv
// group_accumulator: reads NUM_GROUPS x GROUP words from a source RAM,
// sums each group and writes the sums with an overflow flag.
module group_accumulator #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int GROUP      = 8,
    parameter int NUM_GROUPS = 4,
    parameter int SUM_W      = 11,
    parameter int RES_AW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sat_en,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [RES_AW-1:0] res_addr,
    output logic              res_wren,
    output logic [SUM_W-1:0]  res_data,
    output logic              res_ovf
);

    localparam int KW   = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam int PADW = SUM_W + 1 - DATA_W;

    localparam logic [KW-1:0]     K_LAST = KW'(GROUP - 1);
    localparam logic [RES_AW-1:0] G_LAST = RES_AW'(NUM_GROUPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ACC,
        WR,
        DONE
    } state_t;

    state_t            state;
    logic [SUM_W-1:0]  acc;
    logic              ovf;
    logic              sat_q;
    logic [KW-1:0]     k;
    logic [RES_AW-1:0] g;

    logic [SUM_W:0]    sum_full;
    logic              ovf_hit;
    logic [SUM_W-1:0]  acc_nxt;

    // Full-width sum of the running total and the incoming word, then clamp or wrap
    always_comb begin
        sum_full = {1'b0, acc} + {{PADW{1'b0}}, mem_rdata};
        ovf_hit  = sum_full[SUM_W];
        acc_nxt  = sum_full[SUM_W-1:0];
        if (ovf_hit && sat_q) begin
            acc_nxt = '1;
        end
    end

    // Sequencer: the read address is a running pointer, since words of
    // consecutive groups are contiguous in the source RAM
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            ovf      <= 1'b0;
            sat_q    <= 1'b0;
            k        <= '0;
            g        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_addr <= '0;
            mem_rden <= 1'b0;
            res_addr <= '0;
            res_wren <= 1'b0;
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else begin
            mem_rden <= 1'b0;
            res_wren <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sat_q    <= sat_en;
                        acc      <= '0;
                        ovf      <= 1'b0;
                        k        <= '0;
                        g        <= '0;
                        mem_addr <= base_addr;
                        mem_rden <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RD;
                    end
                end
                RD: begin
                    state <= ACC;
                end
                ACC: begin
                    acc <= acc_nxt;
                    ovf <= ovf | ovf_hit;
                    if (k == K_LAST) begin
                        res_wren <= 1'b1;
                        res_addr <= g;
                        res_data <= acc_nxt;
                        res_ovf  <= ovf | ovf_hit;
                        state    <= WR;
                    end else begin
                        k        <= k + KW'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_rden <= 1'b1;
                        state    <= RD;
                    end
                end
                WR: begin
                    acc <= '0;
                    ovf <= 1'b0;
                    k   <= '0;
                    if (g == G_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        g        <= g + RES_AW'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_rden <= 1'b1;
                        state    <= RD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_group_accumulator.sv
// tb_group_accumulator: three parameter sets, random and directed runs,
// queue scoreboard fed by the driver and drained by a monitor.
module tb_group_accumulator;

    localparam int NI = 3;
    localparam int P_DW[NI] = '{8, 8, 8};
    localparam int P_AW[NI] = '{5, 5, 4};
    localparam int P_G [NI] = '{8, 8, 1};
    localparam int P_NG[NI] = '{4, 2, 1};
    localparam int P_SW[NI] = '{11, 9, 8};
    localparam int P_RA[NI] = '{2, 1, 1};
    localparam int NRUN = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_fin = 0;

    task automatic check(input int id, input string name,
                         input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL i%0d %s: got %0d, required %0d (cycle %0d)",
                     id, name, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int DW   = P_DW[gi];
        localparam int AW   = P_AW[gi];
        localparam int G    = P_G[gi];
        localparam int NG   = P_NG[gi];
        localparam int SW   = P_SW[gi];
        localparam int RA   = P_RA[gi];
        localparam int WLEN = 2 * G + 1;
        localparam int RLEN = NG * WLEN;
        localparam int MSZ  = 2 ** AW;

        typedef struct {
            int     addr;
            longint data;
            int     ovf;
            int     at;
        } res_t;

        logic          reset     = 1'b1;
        logic          start     = 1'b0;
        logic          sat_en    = 1'b0;
        logic [AW-1:0] base_addr = '0;
        logic [DW-1:0] mem_rdata = '0;
        logic          busy;
        logic          done;
        logic [AW-1:0] mem_addr;
        logic          mem_rden;
        logic [RA-1:0] res_addr;
        logic          res_wren;
        logic [SW-1:0] res_data;
        logic          res_ovf;

        logic [DW-1:0] mem [MSZ];
        res_t          exp_q[$];
        int            done_q[$];
        int            busy_lo = -1;
        int            busy_hi = -2;
        bit            mon_on  = 1'b0;

        group_accumulator #(
            .DATA_W    (DW),
            .ADDR_W    (AW),
            .GROUP     (G),
            .NUM_GROUPS(NG),
            .SUM_W     (SW),
            .RES_AW    (RA)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .sat_en   (sat_en),
            .base_addr(base_addr),
            .busy     (busy),
            .done     (done),
            .mem_addr (mem_addr),
            .mem_rden (mem_rden),
            .mem_rdata(mem_rdata),
            .res_addr (res_addr),
            .res_wren (res_wren),
            .res_data (res_data),
            .res_ovf  (res_ovf)
        );

        // Source RAM with one cycle read latency
        always @(posedge clk) begin
            if (mem_rden) mem_rdata <= mem[mem_addr];
        end

        // Reference: plain sums of the group's words; results cut off by reset are dropped
        task automatic expect_run(input int s0, input int base,
                                  input bit sat, input int cut);
            res_t   e;
            longint tot;
            longint lim;
            lim = longint'(1) << SW;
            for (int gg = 0; gg < NG; gg++) begin
                tot = 0;
                for (int kk = 0; kk < G; kk++)
                    tot += longint'(mem[(base + gg * G + kk) % MSZ]);
                e.addr = gg;
                e.ovf  = (tot >= lim) ? 1 : 0;
                if (sat) e.data = (tot >= lim) ? lim - 1 : tot;
                else     e.data = tot % lim;
                e.at = s0 + (gg + 1) * WLEN - 1;
                if (e.at < cut) exp_q.push_back(e);
            end
            if (s0 + RLEN < cut) done_q.push_back(s0 + RLEN);
            busy_lo = s0;
            busy_hi = (s0 + RLEN - 1 < cut) ? s0 + RLEN - 1 : cut - 1;
        endtask

        task automatic chk_zero(input string w);
            check(gi, {w, " busy"},     longint'(busy),     0);
            check(gi, {w, " done"},     longint'(done),     0);
            check(gi, {w, " mem_rden"}, longint'(mem_rden), 0);
            check(gi, {w, " mem_addr"}, longint'(mem_addr), 0);
            check(gi, {w, " res_wren"}, longint'(res_wren), 0);
            check(gi, {w, " res_addr"}, longint'(res_addr), 0);
            check(gi, {w, " res_data"}, longint'(res_data), 0);
            check(gi, {w, " res_ovf"},  longint'(res_ovf),  0);
        endtask

        // Monitor: busy window every cycle, writes and done against the queues
        always @(negedge clk) begin : mon
            res_t e;
            int   d;
            if (mon_on) begin
                check(gi, "busy", longint'(busy),
                      (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
                if (res_wren) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL i%0d res_wren: write at cycle %0d, required none",
                                 gi, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check(gi, "wr_cycle", cyc, e.at);
                        check(gi, "res_addr", longint'(res_addr), e.addr);
                        check(gi, "res_data", longint'(res_data), e.data);
                        check(gi, "res_ovf",  longint'(res_ovf),  e.ovf);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL i%0d done: pulse at cycle %0d, required none",
                                 gi, cyc);
                    end else begin
                        d = done_q.pop_front();
                        check(gi, "done_cycle", cyc, d);
                    end
                end
            end
        end

        // Driver: directed runs first, then random ones
        initial begin : drv
            int s0;
            int base;
            int abort;
            int mode;
            int cut;
            bit sat;
            bit hold;
            bit pulse;
            for (int a = 0; a < MSZ; a++) mem[a] = '0;
            repeat (3) @(posedge clk);
            #1;
            chk_zero("reset");
            reset  = 1'b0;
            mon_on = 1'b1;
            hold   = 1'b0;
            for (int r = 0; r < NRUN; r++) begin
                pulse = ($urandom_range(0, 2) == 0);
                abort = 0;
                sat   = 1'(($urandom >> 3) & 1);
                base  = int'($urandom_range(0, MSZ - 1));
                mode  = int'($urandom_range(0, 3));
                for (int a = 0; a < MSZ; a++) begin
                    unique case (mode)
                        0: mem[a] = DW'($urandom);
                        1: mem[a] = '1;
                        2: mem[a] = '0;
                        default: mem[a] = ($urandom_range(0, 1) == 1) ? '1 : '0;
                    endcase
                end
                if (r <= 3) begin
                    for (int a = 0; a < MSZ; a++) mem[a] = DW'(a);
                    base  = (r == 1) ? 30 % MSZ : 0;
                    sat   = 1'b0;
                    pulse = (r == 0);
                    abort = (r == 2) ? 20 : 0;
                end
                if (r == 6 || r == 7) begin
                    for (int j = 0; j < 2 * G; j++)
                        mem[(base + j) % MSZ] = (j < G) ? '1 : '0;
                    sat = (r == 7);
                end
                hold = (r == 4 || r == 5 || r == 8);
                start     = 1'b1;
                base_addr = AW'(base);
                sat_en    = sat;
                @(posedge clk);
                #1;
                s0  = cyc;
                cut = (abort != 0) ? s0 + abort : 32'h7fff_ffff;
                expect_run(s0, base, sat, cut);
                for (int rel = 1; rel <= RLEN + 1; rel++) begin
                    if (pulse && (rel == 5 || rel == 40)) begin
                        start     = 1'b1;
                        base_addr = AW'(base + 7);
                        sat_en    = !sat;
                    end else begin
                        start = hold;
                    end
                    if (abort == rel) reset = 1'b1;
                    @(posedge clk);
                    #1;
                    if (abort == rel) begin
                        reset = 1'b0;
                        chk_zero("abort");
                        break;
                    end
                end
                if (!hold) begin
                    start = 1'b0;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            start = 1'b0;
            repeat (RLEN + 4) @(posedge clk);
            #1;
            check(gi, "pending_writes", exp_q.size(), 0);
            check(gi, "pending_done", done_q.size(), 0);
            n_fin++;
        end
    end

    initial begin
        while (n_fin < NI && cyc < 60000) @(posedge clk);
        #2;
        if (n_fin < NI) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d drivers finished, required %0d", n_fin, NI);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
